ann_layer_sequencer: RTL and testbench

Control FSM for a multi-neuron layer pass over the ANN MAC datapath. On `start` it walks M neurons in order. For each neuron it clears the accumulator, streams N value/weight index offsets, adds the bias, optionally applies the activation, and loads the neuron result. It sits between the top-level network controller, which issues `start`/`hidden`, and the datapath/weight memories, which consume `offset`, `neuron` and the strobes.

---
 rtl/ann_layer_sequencer_if.sv | 30 +++
 rtl/ann_layer_sequencer.sv | 117 +++++++++++
 tb/tb_ann_layer_sequencer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/ann_layer_sequencer_if.sv
// Control and strobe bundle shared by the network controller, the layer sequencer
// and the MAC datapath / weight memories.
interface ann_layer_sequencer_if #(
  parameter int NW = 4,
  parameter int MW = 2
);
  logic          start;
  logic          hidden;
  logic          stall;
  logic [NW-1:0] offset;
  logic [MW-1:0] neuron;
  logic          clr_acc;
  logic          mac_en;
  logic          bias_en;
  logic          act_en;
  logic          ld;
  logic          ready;
  logic          done;
  logic          hidden_q;

  modport master (
    output start, hidden, stall,
    input  offset, neuron, clr_acc, mac_en, bias_en, act_en, ld, ready, done, hidden_q
  );

  modport slave (
    input  start, hidden, stall,
    output offset, neuron, clr_acc, mac_en, bias_en, act_en, ld, ready, done, hidden_q
  );
endinterface

// File: rtl/ann_layer_sequencer.sv
// Layer-pass control FSM: walks M neurons, each as CLEAR, N MAC steps, BIAS,
// optional ACT and LOAD, with stall freezing every step except DONE.
module ann_layer_sequencer #(
  parameter  int N  = 10,
  parameter  int M  = 4,
  localparam int NW = $clog2(N),
  localparam int MW = (M > 1) ? $clog2(M) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ann_layer_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_MAC   = 3'd2,
    S_BIAS  = 3'd3,
    S_ACT   = 3'd4,
    S_LOAD  = 3'd5,
    S_DONE  = 3'd6
  } state_e;

  localparam logic [NW-1:0] OFF_LAST = NW'(N - 1);
  localparam logic [MW-1:0] NEU_LAST = MW'(M - 1);

  state_e        state_q;
  logic [NW-1:0] offset_q;
  logic [MW-1:0] neuron_q;
  logic          hid_q;

  logic clr_s;
  logic mac_s;
  logic bias_s;
  logic act_s;
  logic ld_s;

  // Sequencing state; DONE and IDLE deliberately ignore stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      offset_q <= '0;
      neuron_q <= '0;
      hid_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_q  <= S_CLEAR;
            hid_q    <= bus.hidden;
            neuron_q <= '0;
            offset_q <= '0;
          end
        end
        S_DONE: begin
          state_q  <= S_IDLE;
          neuron_q <= '0;
        end
        default: begin
          if (!bus.stall) begin
            case (state_q)
              S_CLEAR: state_q <= S_MAC;
              S_MAC: begin
                if (offset_q == OFF_LAST) begin
                  offset_q <= '0;
                  state_q  <= S_BIAS;
                end else begin
                  offset_q <= offset_q + NW'(1);
                end
              end
              S_BIAS: state_q <= hid_q ? S_ACT : S_LOAD;
              S_ACT:  state_q <= S_LOAD;
              S_LOAD: begin
                if (neuron_q == NEU_LAST) begin
                  state_q <= S_DONE;
                end else begin
                  neuron_q <= neuron_q + MW'(1);
                  state_q  <= S_CLEAR;
                end
              end
              default: state_q <= S_IDLE;
            endcase
          end
        end
      endcase
    end
  end

  // One-hot strobe decode of the current state, before stall gating.
  always_comb begin
    clr_s  = 1'b0;
    mac_s  = 1'b0;
    bias_s = 1'b0;
    act_s  = 1'b0;
    ld_s   = 1'b0;
    case (state_q)
      S_CLEAR: clr_s  = 1'b1;
      S_MAC:   mac_s  = 1'b1;
      S_BIAS:  bias_s = 1'b1;
      S_ACT:   act_s  = 1'b1;
      S_LOAD:  ld_s   = 1'b1;
      default: clr_s  = 1'b0;
    endcase
  end

  assign bus.clr_acc  = clr_s  & ~bus.stall;
  assign bus.mac_en   = mac_s  & ~bus.stall;
  assign bus.bias_en  = bias_s & ~bus.stall;
  assign bus.act_en   = act_s  & ~bus.stall;
  assign bus.ld       = ld_s   & ~bus.stall;
  assign bus.offset   = offset_q;
  assign bus.neuron   = neuron_q;
  assign bus.ready    = (state_q == S_IDLE);
  assign bus.done     = (state_q == S_DONE);
  assign bus.hidden_q = hid_q;

endmodule

// File: tb/tb_ann_layer_sequencer.sv
// Self-checking bench: per-cycle expected outputs derived from the layer timing
// formulas are queued as stimulus is driven and compared when sampled.
module tb_ann_layer_sequencer;
  localparam int N  = 10;
  localparam int M  = 4;
  localparam int NW = $clog2(N);
  localparam int MW = (M > 1) ? $clog2(M) : 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  ann_layer_sequencer_if #(.NW(NW), .MW(MW)) bus ();

  ann_layer_sequencer #(.N(N), .M(M)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NW-1:0] offset;
    logic [MW-1:0] neuron;
    logic          clr;
    logic          mac;
    logic          bias;
    logic          act;
    logic          ld;
    logic          ready;
    logic          done;
    logic          hq;
  } obs_t;

  typedef struct {
    string name;
    bit    hid;
    int    s;
    int    l;
    int    busy;
    int    exp_done;
    int    exp_mac1;
  } vec_t;

  obs_t sb_q[$];
  int   n_chk = 0;
  int   n_err = 0;
  bit   last_hq = 1'b0;
  vec_t tbl[4];

  function automatic obs_t idle_exp(input bit hq);
    obs_t r;
    r = '0;
    r.ready = 1'b1;
    r.hq = hq;
    return r;
  endfunction

  // Expected outputs in cycle t (t >= 1) of a pass started in cycle 0,
  // with stall held for l cycles starting at cycle s.
  function automatic obs_t model(input int t, input bit hid, input int s, input int l);
    obs_t r;
    int   p_len, e, p;
    bit   stalled;
    r = '0;
    r.hq = hid;
    p_len = N + 3 + (hid ? 1 : 0);
    stalled = (t >= s) && (t < s + l);
    if (stalled) e = s;
    else if (t >= s + l) e = t - l;
    else e = t;
    if (e <= M * p_len) begin
      r.neuron = MW'((e - 1) / p_len);
      p = (e - 1) % p_len;
      if (p >= 1 && p <= N) r.offset = NW'(p - 1);
      if (!stalled) begin
        if (p == 0) r.clr = 1'b1;
        else if (p <= N) r.mac = 1'b1;
        else if (p == N + 1) r.bias = 1'b1;
        else if (hid && p == N + 2) r.act = 1'b1;
        else r.ld = 1'b1;
      end
    end else if (e == M * p_len + 1) begin
      r.done = 1'b1;
      r.neuron = MW'(M - 1);
    end else begin
      r.ready = 1'b1;
    end
    return r;
  endfunction

  function automatic obs_t sample();
    obs_t r;
    r.offset = bus.offset;
    r.neuron = bus.neuron;
    r.clr    = bus.clr_acc;
    r.mac    = bus.mac_en;
    r.bias   = bus.bias_en;
    r.act    = bus.act_en;
    r.ld     = bus.ld;
    r.ready  = bus.ready;
    r.done   = bus.done;
    r.hq     = bus.hidden_q;
    return r;
  endfunction

  task automatic compare(input string name, input int t);
    obs_t exp_o, act_o;
    act_o = sample();
    n_chk++;
    if (sb_q.size() == 0) begin
      n_err++;
      $display("FAIL %s cycle %0d: scoreboard empty, got %h", name, t, act_o);
    end else begin
      exp_o = sb_q.pop_front();
      if (act_o !== exp_o) begin
        n_err++;
        $display("FAIL %s cycle %0d: got %h expected %h (off,neu,clr,mac,bias,act,ld,rdy,done,hq)",
                 name, t, act_o, exp_o);
      end
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    n_chk++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic run_pass(input string name, input bit hid, input int s, input int l,
                          input int busy, output int done_cyc, output int mac1, output int n_ld);
    int last;
    last = M * (N + 3 + (hid ? 1 : 0)) + 2 + l;
    done_cyc = -1;
    mac1 = 0;
    n_ld = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.hidden = hid; bus.stall = 1'b0;
    sb_q.push_back(idle_exp(last_hq));
    #1 compare(name, 0);
    for (int t = 1; t <= last; t++) begin
      @(negedge clk);
      bus.start  = (t == busy);
      bus.hidden = ~hid;
      bus.stall  = (t >= s) && (t < s + l);
      sb_q.push_back(model(t, hid, s, l));
      #1;
      if (bus.done) done_cyc = t;
      if (bus.mac_en && bus.neuron == MW'(1)) mac1++;
      if (bus.ld) n_ld++;
      compare(name, t);
    end
    bus.start = 1'b0;
    bus.stall = 1'b0;
    last_hq = hid;
  endtask

  initial begin
    int dc, m1, nl;
    tbl[0] = '{"hidden_pass", 1'b1, 1000, 0, -1, 57, N};
    tbl[1] = '{"output_pass", 1'b0, 1000, 0, -1, 53, N};
    tbl[2] = '{"stall_pass",  1'b1, 20,   3, -1, 60, N};
    tbl[3] = '{"busy_start",  1'b1, 1000, 0, 20, 57, N};

    bus.start = 1'b0; bus.hidden = 1'b0; bus.stall = 1'b0;
    repeat (2) @(negedge clk);
    sb_q.push_back(idle_exp(1'b0));
    #1 compare("reset", 0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.hidden = 1'($urandom);
      sb_q.push_back(idle_exp(1'b0));
      #1 compare("idle", i);
    end

    for (int v = 0; v < 4; v++) begin
      run_pass(tbl[v].name, tbl[v].hid, tbl[v].s, tbl[v].l, tbl[v].busy, dc, m1, nl);
      check_int({tbl[v].name, "_done_cycle"}, dc, tbl[v].exp_done);
      check_int({tbl[v].name, "_mac_n1"}, m1, tbl[v].exp_mac1);
      check_int({tbl[v].name, "_ld_count"}, nl, M);
    end

    // Mid-pass reset while neuron 2 is in MAC, then a clean pass from scratch.
    @(negedge clk);
    bus.start = 1'b1; bus.hidden = 1'b1; bus.stall = 1'b0;
    sb_q.push_back(idle_exp(last_hq));
    #1 compare("pre_rst", 0);
    for (int t = 1; t <= 33; t++) begin
      @(negedge clk);
      bus.start = 1'b0; bus.hidden = 1'b0;
      sb_q.push_back(model(t, 1'b1, 1000, 0));
      #1 compare("pre_rst", t);
    end
    #2 rst_n = 1'b0;
    sb_q.push_back(idle_exp(1'b0));
    #1 compare("rst_async", 33);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      sb_q.push_back(idle_exp(1'b0));
      #1 compare("rst_hold", i);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back(idle_exp(1'b0));
      #1 compare("rst_release", i);
      @(negedge clk);
    end
    last_hq = 1'b0;
    run_pass("post_rst", 1'b0, 1000, 0, -1, dc, m1, nl);
    check_int("post_rst_done_cycle", dc, 53);
    check_int("post_rst_ld_count", nl, M);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
